// File: rtl/intersection_scheduler.sv
// intersection_scheduler
//   Green-phase arbiter for a two-approach intersection (north-south and
//   east-west) driven through RGB lamps, where yellow is red+green. It
//   enforces minimum/maximum green, yellow, all-red clearance and
//   pedestrian walk intervals. This is the only block allowed to grant green.
//
//   Optional feature macro: PED_WALK_EN.
//     Defined   : pedestrian request latch and WALK phase are built in.
//     Undefined : ped_req is ignored, walk is tied 0, WALK is never entered
//                 and GREEN_MAX has no effect.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   avl       in   enable; 0 forces an all-red hold in CLEAR
//   req_ns    in   level vehicle request, north-south
//   req_ew    in   level vehicle request, east-west
//   ped_req   in   pedestrian request (pulse or level)
//   ns_red    out  north-south red
//   ns_green  out  north-south green (with ns_red = yellow)
//   ew_red    out  east-west red
//   ew_green  out  east-west green (with ew_red = yellow)
//   walk      out  pedestrian walk lamp
//   phase     out  current state code (0..5)
module intersection_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW    = 3,
  parameter int CLEAR     = 2,
  parameter int WALK      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       avl,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_NS_GREEN  = 3'd1,
    S_NS_YELLOW = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_WALK      = 3'd5
  } state_t;

  localparam logic [8:0] L_GREEN_MIN = 9'(GREEN_MIN);
  localparam logic [8:0] L_YELLOW    = 9'(YELLOW);
  localparam logic [8:0] L_CLEAR     = 9'(CLEAR);
  localparam logic [8:0] L_WALK      = 9'(WALK);

  state_t     r_state, w_state_next;
  logic [7:0] r_timer, w_timer_next;
  logic [8:0] w_elapsed;       // cycles in this state including the current one
  logic       r_next_dir, w_next_dir_next;
  logic       w_ped_go;        // CLEAR diverts to WALK
  logic       w_ped_force;     // a pending pedestrian ends a long green
  logic       r_ns_red, r_ns_green, r_ew_red, r_ew_green;

  assign w_elapsed = {1'b0, r_timer} + 9'd1;

`ifdef PED_WALK_EN
  localparam logic [8:0] L_GREEN_MAX = 9'(GREEN_MAX);
  logic r_ped_pending, w_ped_pending_next;
  logic r_walk;

  assign w_ped_go    = r_ped_pending | ped_req;
  assign w_ped_force = r_ped_pending & (w_elapsed >= L_GREEN_MAX);
  assign walk        = r_walk;

  // Clear on WALK entry takes priority over a coincident request.
  always_comb begin
    w_ped_pending_next = r_ped_pending;
    if (w_state_next == S_WALK && r_state != S_WALK)
      w_ped_pending_next = 1'b0;
    else if (ped_req && r_state != S_WALK)
      w_ped_pending_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
    end else begin
      r_ped_pending <= w_ped_pending_next;
      r_walk        <= (w_state_next == S_WALK);
    end
  end
`else
  logic w_unused;
  assign w_ped_go    = 1'b0;
  assign w_ped_force = 1'b0;
  assign walk        = 1'b0;
  assign w_unused    = ped_req ^ (GREEN_MAX > 0);
`endif

  // Next-state logic. avl=0 overrides everything and also freezes next_dir.
  always_comb begin
    w_state_next    = r_state;
    w_next_dir_next = r_next_dir;
    case (r_state)
      S_CLEAR: begin
        if (w_elapsed >= L_CLEAR) begin
          if (w_ped_go)
            w_state_next = S_WALK;
          else
            w_state_next = r_next_dir ? S_EW_GREEN : S_NS_GREEN;
        end
      end
      S_NS_GREEN: begin
        if (w_elapsed >= L_GREEN_MIN && (req_ew || w_ped_force)) begin
          w_state_next    = S_NS_YELLOW;
          w_next_dir_next = 1'b1;
        end
      end
      S_EW_GREEN: begin
        if (w_elapsed >= L_GREEN_MIN && (req_ns || w_ped_force)) begin
          w_state_next    = S_EW_YELLOW;
          w_next_dir_next = 1'b0;
        end
      end
      S_NS_YELLOW, S_EW_YELLOW: begin
        if (w_elapsed >= L_YELLOW)
          w_state_next = S_CLEAR;
      end
      S_WALK: begin
        if (w_elapsed >= L_WALK)
          w_state_next = r_next_dir ? S_EW_GREEN : S_NS_GREEN;
      end
      default: w_state_next = S_CLEAR;
    endcase

    if (!avl) begin
      w_state_next    = S_CLEAR;
      w_next_dir_next = r_next_dir;
    end

    if (!avl || w_state_next != r_state)
      w_timer_next = 8'd0;
    else if (r_timer == 8'hFF)
      w_timer_next = r_timer;
    else
      w_timer_next = r_timer + 8'd1;
  end

  // Lamps are decoded from the next state so they switch on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_timer    <= 8'd0;
      r_next_dir <= 1'b0;
      r_ns_red   <= 1'b1;
      r_ns_green <= 1'b0;
      r_ew_red   <= 1'b1;
      r_ew_green <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_next_dir <= w_next_dir_next;
      r_ns_red   <= (w_state_next != S_NS_GREEN);
      r_ns_green <= (w_state_next == S_NS_GREEN) || (w_state_next == S_NS_YELLOW);
      r_ew_red   <= (w_state_next != S_EW_GREEN);
      r_ew_green <= (w_state_next == S_EW_GREEN) || (w_state_next == S_EW_YELLOW);
    end
  end

  assign ns_red   = r_ns_red;
  assign ns_green = r_ns_green;
  assign ew_red   = r_ew_red;
  assign ew_green = r_ew_green;
  assign phase    = r_state;

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Sequences a two-approach intersection (north-south, east-west) built from RGB-LED traffic lights, where yellow is shown as red+green. It arbitrates the green phase between vehicle-sensor requests and a latched pedestrian request, and enforces minimum and maximum green, yellow, all-red clearance and walk intervals. It sits above the per-light drivers and is the only block allowed to grant green.

## Interface
Parameters:
- GREEN_MIN, 8: minimum green length in cycles (1..255).
- GREEN_MAX, 20: green length after which a pending pedestrian request forces a change (GREEN_MIN..255).
- YELLOW, 3: yellow length in cycles (1..255).
- CLEAR, 2: all-red clearance length in cycles (1..255).
- WALK, 6: pedestrian walk length in cycles (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- avl  in  1  enable; 0 forces all-red hold.
- req_ns  in  1  level vehicle request, north-south.
- req_ew  in  1  level vehicle request, east-west.
- ped_req  in  1  pedestrian request; one-cycle pulse or level.
- ns_red, ns_green  out  1 each  north-south lamp (red+green = yellow).
- ew_red, ew_green  out  1 each  east-west lamp.
- walk  out  1  pedestrian walk lamp (blue channel).
- phase  out  3  current state code.

## Operation
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- States and phase codes: CLEAR=0, NS_GREEN=1, NS_YELLOW=2, EW_GREEN=3, EW_YELLOW=4, WALK=5.
- Internal registers:
  - 8-bit `timer` counts cycles spent in the current state, saturates at 255, and is zeroed on every state change.
  - `next_dir` (0=NS, 1=EW) selects the next approach.
  - `ped_pending` holds a latched pedestrian request.
- Reset values:
  - state CLEAR, timer 0, next_dir NS, ped_pending 0.
  - ns_red=ew_red=1, greens 0, walk 0, phase 0.
- Lamp decode:
  - GREEN: own green=1, red=0.
  - YELLOW: own red=1, green=1.
  - Every other state shows red on both approaches.
  - walk=1 only in WALK.
- Transitions, evaluated each cycle with avl=1:
  - CLEAR, after CLEAR cycles: go to WALK if `ped_pending | ped_req`, else to the green selected by next_dir.
  - X_GREEN, once timer ≥ GREEN_MIN: go to X_YELLOW if the other approach requests. If timer ≥ GREEN_MAX, a pending pedestrian request alone also triggers the change. With no requests, green holds indefinitely (timer saturates).
  - X_YELLOW, after YELLOW cycles: go to CLEAR. On entry to X_YELLOW, next_dir is set to the other approach.
  - WALK, after WALK cycles: go to the green selected by next_dir. ped_pending is cleared on WALK entry.
- Pedestrian latch:
  - ped_req sets ped_pending on any cycle outside WALK.
  - ped_req is ignored during WALK.
  - If set and clear coincide, clear wins.
- Own-approach requests never extend or shorten a green.
- avl=0:
  - The next edge forces CLEAR with timer 0. next_dir and ped_pending are retained.
  - While avl=0, the block stays in CLEAR and the timer does not advance.
  - When avl returns to 1, a full CLEAR interval runs before any green.
- Simultaneous events:
  - avl=0 overrides all transitions.
  - req_ns and req_ew both high: the current green is served to GREEN_MIN, then alternates.

## Timing
- All outputs are registered and change on the same edge as the state register, with no combinational path from inputs to outputs.
- A state with length N shows constant outputs for exactly N cycles.
- An input sampled at edge k affects outputs at edge k+1 at the earliest.
- Worst-case wait for an other-approach vehicle is GREEN_MIN + YELLOW + CLEAR cycles, plus WALK if a pedestrian request is pending.
- Asynchronous reset forces reset values immediately, independent of clk. Deassertion is assumed synchronised upstream.

## Configuration
- Macro: PED_WALK_EN.
- Defined: pedestrian logic as above.
- Undefined:
  - ped_req is ignored, ped_pending is absent, walk is tied 0, and WALK is never entered (phase never 5).
  - GREEN_MAX has no effect.
  - All other behaviour is identical.

## Test plan
- Reset, avl=1, no requests: CLEAR for 2 cycles, then NS_GREEN (phase 1, ns_green=1, ns_red=0, ew_red=1). Green is held for 100 cycles.
- req_ew held high from reset: NS green 8 cycles, NS yellow 3 cycles (ns_red=ns_green=1), CLEAR 2 cycles, then EW_GREEN.
- One-cycle ped_req at NS green cycle 2, no vehicle requests: NS green 20 cycles, yellow 3, CLEAR 2, WALK 6 (walk=1, all red), then EW_GREEN.
- avl dropped at NS green cycle 5 for 4 cycles: all red and phase 0 from the next edge. After avl rises, CLEAR 2 cycles, then NS_GREEN again.
- rst_n driven low mid-EW_YELLOW with clk stopped: outputs go to reset values immediately. After release, the sequence restarts from CLEAR toward NS.
- Built without PED_WALK_EN, ped_req pulsed every 10 cycles: walk stays 0, phase never 5, and NS green is held.
